icache_data_sram_refill_writer: RTL and testbench



---
 rtl/icache_data_sram_refill_writer.sv | 152 +++++++++++++++
 tb/tb_icache_data_sram_refill_writer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_data_sram_refill_writer.sv
// Write-port controller for the L1.5 icache data SRAM: line refills and full-array zero flush.
// Optional macro ICACHE_REFILL_CRITICAL_WORD_FIRST_EN starts each refill at the requested word offset.
module icache_data_sram_refill_writer #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned LineBeats = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_req_i,
  output logic                         flush_done_o,
  input  logic                         refill_req_valid_i,
  output logic                         refill_req_ready_o,
  input  logic [$clog2(NumWords)-1:0]  refill_req_addr_i,
  input  logic                         refill_data_valid_i,
  output logic                         refill_data_ready_o,
  input  logic [DataWidth-1:0]         refill_data_i,
  output logic                         refill_done_o,
  output logic                         busy_o,
  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic [$clog2(NumWords)-1:0]  sram_addr_o,
  output logic [DataWidth-1:0]         sram_wdata_o,
  output logic [(DataWidth+7)/8-1:0]   sram_be_o,
  input  logic                         sram_gnt_i
);

  localparam int unsigned AddrWidth = $clog2(NumWords);
  localparam int unsigned BeatWidth = $clog2(LineBeats);
  localparam int unsigned BeWidth   = (DataWidth + 7) / 8;

  localparam logic [AddrWidth-1:0] LastWord  = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0] OffMask   = AddrWidth'(LineBeats - 1);
  localparam logic [BeatWidth-1:0] LastBeat  = BeatWidth'(LineBeats - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFlush  = 2'd1,
    StRefill = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   flush_cnt_q, flush_cnt_d;
  logic [AddrWidth-1:0]   line_base_q, line_base_d;
  logic [BeatWidth-1:0]   start_off_q, start_off_d;
  logic [BeatWidth-1:0]   beat_cnt_q, beat_cnt_d;
  logic                   flush_done_q, flush_done_d;
  logic                   refill_done_q, refill_done_d;
  logic [BeatWidth-1:0]   req_off;
  logic [BeatWidth-1:0]   beat_off;
  logic                   beat_accept;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign req_off = refill_req_addr_i[BeatWidth-1:0];
`else
  assign req_off = '0;
`endif

  // Beat offset wraps naturally within the line through the BeatWidth-bit sum.
  assign beat_off    = start_off_q + beat_cnt_q;
  assign beat_accept = refill_data_valid_i & sram_gnt_i;

  // Next-state and port drive.
  always_comb begin
    state_d             = state_q;
    flush_cnt_d         = flush_cnt_q;
    line_base_d         = line_base_q;
    start_off_d         = start_off_q;
    beat_cnt_d          = beat_cnt_q;
    flush_done_d        = 1'b0;
    refill_done_d       = 1'b0;
    refill_req_ready_o  = 1'b0;
    refill_data_ready_o = 1'b0;
    sram_req_o          = 1'b0;
    sram_we_o           = 1'b0;
    sram_addr_o         = '0;
    sram_wdata_o        = '0;
    sram_be_o           = '0;

    unique case (state_q)
      StIdle: begin
        refill_req_ready_o = ~flush_req_i;
        if (flush_req_i) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
        end else if (refill_req_valid_i) begin
          state_d     = StRefill;
          line_base_d = refill_req_addr_i & ~OffMask;
          start_off_d = req_off;
          beat_cnt_d  = '0;
        end
      end

      StFlush: begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_be_o   = {BeWidth{1'b1}};
        sram_addr_o = flush_cnt_q;
        if (sram_gnt_i) begin
          flush_cnt_d = flush_cnt_q + AddrWidth'(1);
          if (flush_cnt_q == LastWord) begin
            state_d      = StIdle;
            flush_done_d = 1'b1;
          end
        end
      end

      StRefill: begin
        sram_req_o          = refill_data_valid_i;
        refill_data_ready_o = beat_accept;
        sram_we_o           = 1'b1;
        sram_be_o           = {BeWidth{1'b1}};
        sram_wdata_o        = refill_data_i;
        sram_addr_o         = line_base_q | AddrWidth'(beat_off);
        if (beat_accept) begin
          beat_cnt_d = beat_cnt_q + BeatWidth'(1);
          if (beat_cnt_q == LastBeat) begin
            state_d       = StIdle;
            refill_done_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      flush_cnt_q   <= '0;
      line_base_q   <= '0;
      start_off_q   <= '0;
      beat_cnt_q    <= '0;
      flush_done_q  <= 1'b0;
      refill_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      line_base_q   <= line_base_d;
      start_off_q   <= start_off_d;
      beat_cnt_q    <= beat_cnt_d;
      flush_done_q  <= flush_done_d;
      refill_done_q <= refill_done_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign flush_done_o  = flush_done_q;
  assign refill_done_o = refill_done_q;

endmodule

// File: tb/tb_icache_data_sram_refill_writer.sv
// Randomized self-checking bench for icache_data_sram_refill_writer with a line-order reference model.
module tb_icache_data_sram_refill_writer;

  localparam int NW  = 256;
  localparam int DW  = 128;
  localparam int LB  = 4;
  localparam int AW  = $clog2(NW);
  localparam int BEW = (DW + 7) / 8;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif
  localparam logic [BEW-1:0] AllOnes = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_req;
  logic          flush_done;
  logic          rreq_valid;
  logic          rreq_ready;
  logic [AW-1:0] rreq_addr;
  logic          rdata_valid;
  logic          rdata_ready;
  logic [DW-1:0] rdata;
  logic          rdone;
  logic          busy;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BEW-1:0] sram_be;
  logic          sram_gnt;

  icache_data_sram_refill_writer #(.NumWords(NW), .DataWidth(DW), .LineBeats(LB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_req_i(flush_req), .flush_done_o(flush_done),
    .refill_req_valid_i(rreq_valid), .refill_req_ready_o(rreq_ready),
    .refill_req_addr_i(rreq_addr),
    .refill_data_valid_i(rdata_valid), .refill_data_ready_o(rdata_ready),
    .refill_data_i(rdata), .refill_done_o(rdone), .busy_o(busy),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_gnt_i(sram_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    logic          we;
    logic [BEW-1:0] be;
    logic          gnt;
    int            cyc;
  } ev_t;

  ev_t wr_log[$];
  ev_t req_log[$];
  int  fdone_log[$];
  int  rdone_log[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  logic [DW-1:0] beats [LB];

  always @(posedge clk) cyc <= cyc + 1;

  // Observes the SRAM port a few ns after each edge.
  always begin
    ev_t e;
    @(posedge clk);
    #3;
    e.addr = int'(sram_addr); e.data = sram_wdata; e.we = sram_we;
    e.be = sram_be; e.gnt = sram_gnt; e.cyc = cyc;
    if (sram_req) req_log.push_back(e);
    if (sram_req && sram_gnt) wr_log.push_back(e);
    if (flush_done) fdone_log.push_back(cyc);
    if (rdone) rdone_log.push_back(cyc);
  end

  // Reference: word written by beat k of a refill requested at address a.
  function automatic int exp_addr(int a, int k);
    int base, off0;
    base = a - (a % LB);
    off0 = Cwf ? (a % LB) : 0;
    return base + ((off0 + k) % LB);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #3; endtask

  task automatic clear_logs();
    wr_log.delete(); req_log.delete(); fdone_log.delete(); rdone_log.delete();
  endtask

  // Issues one refill with optional stalls; ends at the sample point of the done cycle.
  task automatic run_refill(input int a, input int gnt_beat, input int gnt_cyc,
                            input int val_beat, input int val_cyc, output int acc);
    bit got;
    acc = -1;
    rreq_valid = 1'b1;
    rreq_addr  = AW'(a);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      settle();
      if (rreq_ready) begin got = 1'b1; acc = cyc; end
      else tick();
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL refill_accept_timeout addr=%0h", a);
      rreq_valid = 1'b0;
      return;
    end
    tick();
    rreq_valid = 1'b0;
    for (int k = 0; k < LB; k++) begin
      if (k == val_beat) repeat (val_cyc) begin rdata_valid = 1'b0; tick(); end
      rdata_valid = 1'b1;
      rdata = beats[k];
      if (k == gnt_beat) repeat (gnt_cyc) begin sram_gnt = 1'b0; tick(); end
      sram_gnt = 1'b1;
      tick();
    end
    rdata_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      settle();
      if (rdone) got = 1'b1;
      else tick();
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL refill_done_timeout addr=%0h", a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_req = 0; rreq_valid = 0; rreq_addr = '0;
    rdata_valid = 0; rdata = '0; sram_gnt = 1'b1;
    repeat (3) tick();
    settle();
    vectors++;
    if ({sram_req, sram_we, sram_addr, sram_wdata, sram_be} !== '0) begin
      miscompares++; $display("FAIL reset_sram got req=%b we=%b addr=%h be=%h exp all 0",
                              sram_req, sram_we, sram_addr, sram_be);
    end
    vectors++;
    if (rreq_ready !== 1'b1 || busy !== 1'b0 || flush_done !== 1'b0 || rdone !== 1'b0 ||
        rdata_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl got ready=%b busy=%b fd=%b rd=%b dr=%b exp 1 0 0 0 0",
                              rreq_ready, busy, flush_done, rdone, rdata_ready);
    end
    tick();
    rst_n = 1'b1;
    tick(); settle();
    vectors++;
    if (sram_req !== 1'b0 || rreq_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset got req=%b ready=%b busy=%b exp 0 1 0",
                              sram_req, rreq_ready, busy);
    end
    tick();
  endtask

  task automatic test_refill_order();
    int addrs[2] = '{32'h25, 32'hFF};
    int acc;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < LB; k++) beats[k] = DW'(32'hA + k);
      clear_logs();
      run_refill(addrs[t], -1, 0, -1, 0, acc);
      vectors++;
      if (wr_log.size() !== LB) begin
        miscompares++; $display("FAIL order_count addr=%0h got %0d exp %0d", addrs[t], wr_log.size(), LB);
      end else begin
        for (int k = 0; k < LB; k++) begin
          vectors++;
          if (wr_log[k].addr !== exp_addr(addrs[t], k) || wr_log[k].data !== beats[k] ||
              wr_log[k].we !== 1'b1 || wr_log[k].be !== AllOnes || wr_log[k].addr > NW - 1 ||
              (k > 0 && wr_log[k].cyc !== wr_log[k-1].cyc + 1)) begin
            miscompares++; $display("FAIL order_beat%0d addr=%0h got a=%0h d=%0h exp a=%0h d=%0h",
                                    k, addrs[t], wr_log[k].addr, wr_log[k].data, exp_addr(addrs[t], k), beats[k]);
          end
        end
        vectors++;
        if (rdone_log.size() !== 1 || rdone_log[0] !== wr_log[LB-1].cyc + 1 || rdone_log[0] !== acc + LB + 1) begin
          miscompares++; $display("FAIL order_done addr=%0h got n=%0d cyc=%0d exp cyc=%0d",
                                  addrs[t], rdone_log.size(), rdone_log.size() ? rdone_log[0] : -1, acc + LB + 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_refill_stall();
    int a, acc, n_hold, n_held_ok;
    a = 32'h25;
    for (int k = 0; k < LB; k++) beats[k] = rand_word();
    clear_logs();
    run_refill(a, 1, 3, 2, 2, acc);
    n_hold = 0; n_held_ok = 0;
    foreach (req_log[i]) if (!req_log[i].gnt) begin
      n_hold++;
      if (req_log[i].addr == exp_addr(a, 1) && req_log[i].data == beats[1]) n_held_ok++;
    end
    vectors++;
    if (n_hold !== 3 || n_held_ok !== 3 || req_log.size() !== LB + 3) begin
      miscompares++; $display("FAIL stall_hold got held=%0d ok=%0d reqs=%0d exp 3 3 %0d",
                              n_hold, n_held_ok, req_log.size(), LB + 3);
    end
    vectors++;
    if (wr_log.size() !== LB) begin
      miscompares++; $display("FAIL stall_count got %0d exp %0d", wr_log.size(), LB);
    end else begin
      for (int k = 0; k < LB; k++) begin
        vectors++;
        if (wr_log[k].addr !== exp_addr(a, k) || wr_log[k].data !== beats[k]) begin
          miscompares++; $display("FAIL stall_beat%0d got a=%0h exp a=%0h", k, wr_log[k].addr, exp_addr(a, k));
        end
      end
      vectors++;
      if (rdone_log.size() !== 1 || rdone_log[0] !== wr_log[LB-1].cyc + 1) begin
        miscompares++; $display("FAIL stall_done got n=%0d exp 1 at cyc %0d", rdone_log.size(), wr_log[LB-1].cyc + 1);
      end
    end
    tick();
  endtask

  task automatic test_flush_priority();
    int acc, bad;
    bit got;
    clear_logs();
    flush_req = 1'b1; rreq_valid = 1'b1; rreq_addr = AW'(32'h25); sram_gnt = 1'b1;
    settle();
    vectors++;
    if (rreq_ready !== 1'b0) begin
      miscompares++; $display("FAIL flush_prio_ready got %b exp 0", rreq_ready);
    end
    tick();
    flush_req = 1'b0;
    settle();
    vectors++;
    if (busy !== 1'b1 || rreq_ready !== 1'b0) begin
      miscompares++; $display("FAIL flush_busy got busy=%b ready=%b exp 1 0", busy, rreq_ready);
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (fdone_log.size() > 0) got = 1'b1;
      else begin tick(); settle(); end
    end
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL flush_done_timeout got writes=%0d exp %0d", wr_log.size(), NW);
    end
    bad = 0;
    vectors++;
    if (wr_log.size() !== NW) bad++;
    else foreach (wr_log[i])
      if (wr_log[i].addr !== i || wr_log[i].data !== '0 || wr_log[i].be !== AllOnes || wr_log[i].we !== 1'b1) bad++;
    if (bad != 0) begin
      miscompares++; $display("FAIL flush_writes got n=%0d bad=%0d exp n=%0d bad=0", wr_log.size(), bad, NW);
    end
    vectors++;
    if (fdone_log.size() !== 1 || wr_log.size() == 0 || fdone_log[0] !== wr_log[wr_log.size()-1].cyc + 1) begin
      miscompares++; $display("FAIL flush_done_pulse got n=%0d exp 1 pulse after last grant", fdone_log.size());
    end
    for (int k = 0; k < LB; k++) beats[k] = rand_word();
    clear_logs();
    run_refill(32'h25, -1, 0, -1, 0, acc);
    vectors++;
    if (wr_log.size() !== LB || wr_log[0].addr !== exp_addr(32'h25, 0) ||
        wr_log[LB-1].data !== beats[LB-1] || rdone_log.size() !== 1) begin
      miscompares++; $display("FAIL refill_after_flush got writes=%0d dones=%0d exp %0d 1",
                              wr_log.size(), rdone_log.size(), LB);
    end
    tick();
  endtask

  task automatic test_flush_gnt_toggle();
    int bad;
    bit got;
    clear_logs();
    flush_req = 1'b1; sram_gnt = 1'b1;
    tick();
    flush_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin
      settle();
      if (fdone_log.size() > 0) got = 1'b1;
      else begin tick(); sram_gnt = ~sram_gnt; end
    end
    sram_gnt = 1'b1;
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL toggle_done_timeout got writes=%0d exp %0d", wr_log.size(), NW);
    end
    bad = 0;
    vectors++;
    if (wr_log.size() !== NW) bad++;
    else foreach (wr_log[i]) if (wr_log[i].addr !== i || wr_log[i].data !== '0) bad++;
    if (bad != 0) begin
      miscompares++; $display("FAIL toggle_writes got n=%0d bad=%0d exp n=%0d bad=0", wr_log.size(), bad, NW);
    end
    vectors++;
    if (fdone_log.size() !== 1 || wr_log.size() == 0 || fdone_log[0] !== wr_log[wr_log.size()-1].cyc + 1) begin
      miscompares++; $display("FAIL toggle_done_pulse got n=%0d exp 1 pulse after grant of last word", fdone_log.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int a, acc, prev_done;
    prev_done = -1;
    for (int t = 0; t < 8; t++) begin
      a = $urandom_range(NW - 1, 0);
      for (int k = 0; k < LB; k++) beats[k] = rand_word();
      clear_logs();
      run_refill(a, $urandom_range(LB - 1, 0), $urandom_range(2, 0),
                 $urandom_range(LB - 1, 0), $urandom_range(2, 0), acc);
      vectors++;
      if (prev_done >= 0 && (acc < prev_done || acc > prev_done + 1)) begin
        miscompares++; $display("FAIL b2b_accept%0d got cyc=%0d exp within 1 of %0d", t, acc, prev_done);
      end
      vectors++;
      if (wr_log.size() !== LB) begin
        miscompares++; $display("FAIL b2b_count%0d got %0d exp %0d", t, wr_log.size(), LB);
      end else begin
        for (int k = 0; k < LB; k++) begin
          vectors++;
          if (wr_log[k].addr !== exp_addr(a, k) || wr_log[k].data !== beats[k]) begin
            miscompares++; $display("FAIL b2b%0d_beat%0d addr=%0h got a=%0h exp a=%0h",
                                    t, k, a, wr_log[k].addr, exp_addr(a, k));
          end
        end
      end
      prev_done = (rdone_log.size() > 0) ? rdone_log[0] : -1;
    end
    tick();
  endtask

  task automatic test_reset_mid_refill();
    clear_logs();
    rreq_valid = 1'b1; rreq_addr = AW'(32'h40);
    tick();
    rreq_valid = 1'b0;
    rdata_valid = 1'b1; rdata = rand_word();
    tick(); tick();
    rst_n = 1'b0;
    settle();
    vectors++;
    if ({sram_req, sram_we, sram_addr, sram_wdata, sram_be} !== '0 || rreq_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_outputs got req=%b we=%b ready=%b busy=%b exp 0 0 1 0",
                              sram_req, sram_we, rreq_ready, busy);
    end
    wr_log.delete();
    tick(); tick();
    rdata_valid = 1'b0;
    settle();
    vectors++;
    if (wr_log.size() !== 0 || rdone_log.size() !== 0 || sram_req !== 1'b0) begin
      miscompares++; $display("FAIL midreset_no_writes got writes=%0d dones=%0d exp 0 0", wr_log.size(), rdone_log.size());
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_refill_order();
    test_refill_stall();
    test_flush_priority();
    test_flush_gnt_toggle();
    test_back_to_back();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
